alu_share_ctrl: RTL and testbench

//  Time-shares one ALU instance between two requesters: port 0 (execute stage) and port 1
//  (address/branch-compare unit). Round-robin arbitration, valid/ready request channel,

---
 rtl/alu_share_ctrl_pkg.sv | 24 ++
 rtl/alu_share_ctrl_if.sv | 54 +++++
 rtl/alu_share_ctrl_rr_arb2.sv | 15 +
 rtl/alu_share_ctrl.sv | 112 +++++++++++
 tb/tb_alu_share_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU time-sharing controller: op codes, default widths,
// FSM state type and the op legality helper.
package alu_share_ctrl_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_SLL, ALU_SLR};
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the two request/response channels, the ALU-facing signals and busy.
// slave = the controller, master = requesters plus the parent-owned ALU.
interface alu_share_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_neg;
  logic              rsp_err;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_negative;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_neg, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_negative,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_neg, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_negative,
    input  busy
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, ptr breaks ties.
module alu_share_ctrl_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external ALU between two requesters with round-robin grant,
// one transaction in flight, and a held response per requester.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = ALU_DATA_W,
  parameter int unsigned OP_W        = ALU_OP_W,
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  alu_share_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 1);

  state_t            state;
  logic              rr_ptr;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        rsp_valid;
  logic [1:0]        grant;
  logic              idle;
  logic              handshake;
  logic              sel_port;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              owner_ready;

  alu_share_ctrl_rr_arb2 u_arb (
    .req   ({bus.req1_valid, bus.req0_valid}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign idle       = (state == IDLE);
  assign handshake  = idle && (grant != 2'b00);
  assign sel_port   = grant[1];
  assign sel_op     = sel_port ? bus.req1_op : bus.req0_op;
  assign sel_a      = sel_port ? bus.req1_a  : bus.req0_a;
  assign sel_b      = sel_port ? bus.req1_b  : bus.req0_b;
  assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = idle && grant[0];
  assign bus.req1_ready = idle && grant[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.busy       = !idle;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= 1'b0;
      owner          <= 1'b0;
      cnt            <= '0;
      rsp_valid      <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= ALU_ADD;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_neg    <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner <= sel_port;
            if (alu_op_legal(sel_op)) begin
              bus.alu_op <= sel_op;
              bus.alu_a  <= sel_a;
              bus.alu_b  <= sel_b;
              cnt        <= CNT_W'(ALU_LATENCY);
              state      <= EXEC;
            end else begin
              // Illegal op bypasses the ALU; operand registers keep their last values.
              bus.rsp_result <= '0;
              bus.rsp_zero   <= 1'b1;
              bus.rsp_neg    <= 1'b0;
              bus.rsp_err    <= 1'b1;
              rsp_valid      <= grant;
              state          <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt <= CNT_W'(1)) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp_neg    <= bus.alu_negative;
            bus.rsp_err    <= 1'b0;
            rsp_valid      <= owner ? 2'b10 : 2'b01;
            state          <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (owner_ready) begin
            rsp_valid <= '0;
            rr_ptr    <= !owner;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed scenarios plus random two-port traffic,
// with a one-register ALU model standing in for the parent-owned ALU.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        err;
  } rsp_t;

  typedef struct {
    bit   port;
    rsp_t r;
    int   hs;
    int   due;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alu_share_ctrl_if #(.DATA_W(32), .OP_W(3)) bus ();

  alu_share_ctrl #(.DATA_W(32), .OP_W(3), .ALU_LATENCY(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t q[$];
  int   last_srv = -1;
  logic [1:0]  prev_rv = 2'b00;
  logic [1:0]  rv;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_op = '0;
  bit   rnd_on = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    logic [31:0] v;
    if (op > 3'd4) begin
      r.result = '0; r.zero = 1'b1; r.neg = 1'b0; r.err = 1'b1;
      return r;
    end
    case (op)
      3'd0:    v = a + b;
      3'd1:    v = a - b;
      3'd2:    v = a & b;
      3'd3:    v = (b > 32'd31) ? 32'd0 : a << b;
      default: v = (b > 32'd31) ? 32'd0 : a >> b;
    endcase
    r.result = v; r.zero = (v == 32'd0); r.neg = v[31]; r.err = 1'b0;
    return r;
  endfunction

  // Parent-side ALU: result follows the operand registers one clock later.
  rsp_t alu_pipe = '0;
  always @(posedge clock) alu_pipe <= model(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_result   = alu_pipe.result;
  assign bus.alu_zero     = alu_pipe.zero;
  assign bus.alu_negative = alu_pipe.neg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.port = p;
    e.r    = model(op, a, b);
    e.hs   = cyc + 1;
    e.due  = e.hs + (e.r.err ? 0 : LAT);
    if (!e.r.err) begin
      m_op = op; m_a = a; m_b = b;
    end
    q.push_back(e);
  endtask

  // Monitor: response checks first (state before this edge), then newly accepted requests.
  always @(negedge clock) begin
    rv = {bus.rsp1_valid, bus.rsp0_valid};
    if (!reset_n) begin
      q.delete();
      m_a = '0; m_b = '0; m_op = '0;
      last_srv = -1;
      prev_rv = 2'b00;
    end else begin
      if (q.size() == 0) begin
        if (rv != 2'b00) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got valid %b expected 00 (cycle %0d)", rv, cyc);
        end else begin
          chk("idle_busy", 64'(bus.busy), 64'd0);
        end
      end else if (rv != 2'b00) begin
        chk("rsp_port", 64'(rv), q[0].port ? 64'd2 : 64'd1);
        chk("rsp_data", 64'({bus.rsp_result, bus.rsp_zero, bus.rsp_neg, bus.rsp_err}), 64'(q[0].r));
        if (prev_rv == 2'b00) chk("rsp_cycle", 64'(cyc), 64'(q[0].due));
        chk("alu_ab", {bus.alu_a, bus.alu_b}, {m_a, m_b});
        chk("alu_op_busy_ready", 64'({bus.alu_op, bus.busy, bus.req1_ready, bus.req0_ready}),
            64'({m_op, 3'b100}));
        if (q[0].port ? bus.rsp1_ready : bus.rsp0_ready) begin
          last_srv = int'(q[0].port);
          void'(q.pop_front());
        end
      end else if (cyc >= q[0].hs) begin
        chk("exec_busy_ready", 64'({bus.busy, bus.req1_ready, bus.req0_ready}), 64'd4);
      end
      if (bus.req0_valid && bus.req1_valid && (bus.req0_ready || bus.req1_ready))
        chk("arb_grant", 64'({bus.req1_ready, bus.req0_ready}), (last_srv == 0) ? 64'd2 : 64'd1);
      if (bus.req0_valid && bus.req0_ready) push(1'b0, bus.req0_op, bus.req0_a, bus.req0_b);
      if (bus.req1_valid && bus.req1_ready) push(1'b1, bus.req1_op, bus.req1_a, bus.req1_b);
      prev_rv = rv;
    end
  end

  task automatic drive(input bit p, input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (p) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge (or after withdrawal).
  task automatic issue(input bit p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit tease);
    int n;
    n = 0;
    drive(p, 1'b1, op, a, b);
    @(negedge clock);
    while (!(p ? bus.req1_ready : bus.req0_ready) && !tease && n < 400) begin
      n++;
      @(negedge clock);
    end
    if (n >= 400) begin
      n_vec++; n_err++;
      $display("FAIL req%0d_grant_timeout: got no ready expected ready within 400 cycles", p);
    end
    @(posedge clock); #1;
    drive(p, 1'b0, op, a, b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while ((bus.busy || q.size() != 0) && n < 500);
    if (n >= 500) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: got busy=%b pending=%0d expected idle", bus.busy, q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    chk("reset_outputs", 64'({bus.alu_op, bus.rsp_result, bus.rsp_zero, bus.rsp_neg, bus.rsp_err,
                              bus.rsp1_valid, bus.rsp0_valid, bus.busy}), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic rnd_driver(input bit p, input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      repeat ($urandom_range(0, 4)) begin @(posedge clock); #1; end
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = $urandom;
      b  = (op == ALU_SLL || op == ALU_SLR) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      issue(p, op, a, b, ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    #200000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    do_reset();

    issue(1'b0, ALU_ADD, 32'd5, 32'd7, 1'b0);
    wait_idle();

    do_reset();
    fork
      issue(1'b0, ALU_SUB, 32'd3, 32'd5, 1'b0);
      issue(1'b1, ALU_AND, 32'hF0, 32'h3C, 1'b0);
    join
    wait_idle();
    fork
      issue(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
      issue(1'b1, ALU_SLR, 32'h8000_0000, 32'd31, 1'b0);
    join
    wait_idle();

    issue(1'b0, ALU_SUB, 32'd9, 32'd4, 1'b0);
    wait_idle();
    issue(1'b1, 3'd6, 32'd1, 32'd2, 1'b0);
    wait_idle();

    bus.rsp0_ready = 1'b0;
    issue(1'b0, ALU_ADD, 32'h1234, 32'h1111, 1'b0);
    fork
      issue(1'b1, ALU_AND, 32'hFF00, 32'h0FF0, 1'b0);
      begin
        repeat (LAT + 5) @(posedge clock);
        #1 bus.rsp0_ready = 1'b1;
      end
    join
    wait_idle();

    issue(1'b0, ALU_ADD, 32'd1, 32'd1, 1'b0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_mid_exec", 64'({bus.busy, bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    repeat (10) @(posedge clock);
    #1;

    repeat (3) begin
      issue(1'b1, ALU_SLL, 32'd1, 32'd4, 1'b0);
      wait_idle();
    end

    rnd_on = 1;
    fork
      begin
        fork
          rnd_driver(1'b0, 40);
          rnd_driver(1'b1, 40);
        join
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(posedge clock); #1;
          bus.rsp0_ready = ($urandom_range(0, 3) != 0);
          bus.rsp1_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
